// File: rtl/ysyx_22050133_mul_ctrl.sv
// Multiply control FSM between the EXU, an external multiplier and writeback.
// Ports: clk/rst, EXU in_* / op / src* / flush, multiplier mul_* / result_*, wb_*.
module ysyx_22050133_mul_ctrl (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [2:0]  op,
   input  logic [63:0] src1,
   input  logic [63:0] src2,
   input  logic [4:0]  in_rd,
   input  logic        flush,
   output logic        mul_valid,
   input  logic        mul_ready,
   output logic        mulw,
   output logic [1:0]  mul_signed,
   output logic [63:0] multiplicand,
   output logic [63:0] multiplier,
   output logic        mul_flush,
   input  logic        out_valid,
   input  logic [63:0] result_hi,
   input  logic [63:0] result_lo,
   output logic        wb_valid,
   input  logic        wb_ready,
   output logic [63:0] wb_data,
   output logic [4:0]  wb_rd
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_DONE
   } state_e;

   typedef enum logic [1:0] {
      SEL_LO,
      SEL_HI,
      SEL_W
   } sel_e;

   state_e      state_q, state_d;
   sel_e        sel_q, sel_d;
   logic        mul_valid_q, mul_valid_d;
   logic        mulw_q, mulw_d;
   logic [1:0]  mul_signed_q, mul_signed_d;
   logic [63:0] mcand_q, mcand_d;
   logic [63:0] mplier_q, mplier_d;
   logic        wb_valid_q, wb_valid_d;
   logic [63:0] wb_data_q, wb_data_d;
   logic [4:0]  wb_rd_q, wb_rd_d;

   logic [2:0]  op_eff;
   logic        dec_w;
   logic [1:0]  dec_sgn;
   sel_e        dec_sel;
   logic        src_zero;

   // Unused opcodes 5-7 fall back to plain MUL.
   assign op_eff = (op > 3'd4) ? 3'd0 : op;
   assign dec_w  = (op_eff == 3'd4);

   always_comb begin
      dec_sgn = 2'b11;
      dec_sel = SEL_LO;
      unique case (op_eff)
         3'd1: begin dec_sgn = 2'b11; dec_sel = SEL_HI; end
         3'd2: begin dec_sgn = 2'b10; dec_sel = SEL_HI; end
         3'd3: begin dec_sgn = 2'b00; dec_sel = SEL_HI; end
         3'd4: begin dec_sgn = 2'b11; dec_sel = SEL_W;  end
         default: begin dec_sgn = 2'b11; dec_sel = SEL_LO; end
      endcase
   end

   // Only the operand bits the op actually consumes decide the bypass.
   always_comb begin
      if (dec_w)
         src_zero = (src1[31:0] == 32'd0) || (src2[31:0] == 32'd0);
      else
         src_zero = (src1 == 64'd0) || (src2 == 64'd0);
   end

   assign in_ready  = (state_q == S_IDLE) && !flush;
   assign mul_flush = flush;

   always_comb begin
      state_d      = state_q;
      sel_d        = sel_q;
      mul_valid_d  = mul_valid_q;
      mulw_d       = mulw_q;
      mul_signed_d = mul_signed_q;
      mcand_d      = mcand_q;
      mplier_d     = mplier_q;
      wb_valid_d   = wb_valid_q;
      wb_data_d    = wb_data_q;
      wb_rd_d      = wb_rd_q;
      if (flush) begin
         state_d     = S_IDLE;
         mul_valid_d = 1'b0;
         wb_valid_d  = 1'b0;
         wb_data_d   = 64'd0;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (in_valid) begin
                  sel_d        = dec_sel;
                  mulw_d       = dec_w;
                  mul_signed_d = dec_sgn;
                  mcand_d      = src1;
                  mplier_d     = src2;
                  wb_rd_d      = in_rd;
                  if (src_zero) begin
                     state_d    = S_DONE;
                     wb_valid_d = 1'b1;
                     wb_data_d  = 64'd0;
                  end else begin
                     state_d     = S_ISSUE;
                     mul_valid_d = 1'b1;
                  end
               end
            end
            S_ISSUE: begin
               if (mul_ready) begin
                  state_d     = S_WAIT;
                  mul_valid_d = 1'b0;
               end
            end
            S_WAIT: begin
               if (out_valid) begin
                  state_d    = S_DONE;
                  wb_valid_d = 1'b1;
                  unique case (sel_q)
                     SEL_HI:  wb_data_d = result_hi;
                     SEL_W:   wb_data_d = {{32{result_lo[31]}}, result_lo[31:0]};
                     default: wb_data_d = result_lo;
                  endcase
               end
            end
            S_DONE: begin
               if (wb_ready) begin
                  state_d    = S_IDLE;
                  wb_valid_d = 1'b0;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= S_IDLE;
         sel_q        <= SEL_LO;
         mul_valid_q  <= 1'b0;
         mulw_q       <= 1'b0;
         mul_signed_q <= 2'b00;
         mcand_q      <= 64'd0;
         mplier_q     <= 64'd0;
         wb_valid_q   <= 1'b0;
         wb_data_q    <= 64'd0;
         wb_rd_q      <= 5'd0;
      end else begin
         state_q      <= state_d;
         sel_q        <= sel_d;
         mul_valid_q  <= mul_valid_d;
         mulw_q       <= mulw_d;
         mul_signed_q <= mul_signed_d;
         mcand_q      <= mcand_d;
         mplier_q     <= mplier_d;
         wb_valid_q   <= wb_valid_d;
         wb_data_q    <= wb_data_d;
         wb_rd_q      <= wb_rd_d;
      end
   end

   assign mul_valid    = mul_valid_q;
   assign mulw         = mulw_q;
   assign mul_signed   = mul_signed_q;
   assign multiplicand = mcand_q;
   assign multiplier   = mplier_q;
   assign wb_valid     = wb_valid_q;
   assign wb_data      = wb_data_q;
   assign wb_rd        = wb_rd_q;

endmodule

// File: doc/ysyx_22050133_mul_ctrl.md
YSYX_22050133_MUL_CTRL -- requirements
Module: ysyx_22050133_mul_ctrl

Interface
REQ-001 SHALL be clocked by one clock and reset asynchronously, active-low: clk  in  1  clock (rising edge); rst  in  1  asynchronous reset, active-low (0 = reset).
REQ-002 SHALL provide upstream (EXU) ports: in_valid in 1 op offered; in_ready out 1 block idle; op in 3 (0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 MULW); src1 in 64 rs1; src2 in 64 rs2; in_rd in 5 destination tag; flush in 1 cancel current op.
REQ-003 SHALL provide multiplier-side ports: mul_valid out 1; mul_ready in 1; mulw out 1; mul_signed out 2; multiplicand out 64; multiplier out 64; mul_flush out 1; out_valid in 1; result_hi in 64; result_lo in 64.
REQ-004 SHALL provide writeback ports: wb_valid out 1; wb_ready in 1; wb_data out 64; wb_rd out 5.

Function
REQ-005 SHALL implement FSM IDLE, ISSUE, WAIT, DONE; in_ready = 1 only in IDLE with flush low.
REQ-006 SHALL accept an op on in_valid & in_ready, registering op, src1, src2 and in_rd; op codes 5-7 SHALL be executed as MUL.
REQ-007 SHALL drive mul_signed 2'b11 for MUL/MULH/MULW, 2'b10 for MULHSU, 2'b00 for MULHU; mulw = 1 only for MULW; multiplicand = src1, multiplier = src2 (registered).
REQ-008 SHALL compute the zero test on the operand bits used (low 32 for MULW, all 64 otherwise); if either is zero, IDLE -> DONE with wb_data = 0 and mul_valid never asserted.
REQ-009 Otherwise IDLE -> ISSUE; in ISSUE, mul_valid = 1 with stable operands until mul_ready = 1, then -> WAIT, mul_valid = 0 the next cycle.
REQ-010 SHALL ignore out_valid in every state except WAIT (a stale level from the previous op is not a result).
REQ-011 In WAIT, on out_valid = 1 SHALL register the result and -> DONE: MUL -> result_lo; MULH/MULHSU/MULHU -> result_hi; MULW -> sign-extend result_lo[31:0] to 64.
REQ-012 In DONE, wb_valid = 1 with wb_data and wb_rd stable until wb_ready = 1; on that cycle -> IDLE, and no new op is accepted in the same cycle.
REQ-013 Latency: bypass op accepted at edge t shows wb_valid at t+1; normal op shows wb_valid one cycle after the out_valid cycle seen in WAIT.
REQ-014 flush = 1 in any state SHALL force -> IDLE at the next edge, discard the held op/result, drop wb_valid and mul_valid at that edge; mul_flush = flush combinationally.
REQ-015 flush with in_valid the same cycle: op NOT accepted; flush with wb_ready in DONE: handled as flush (no writeback credited).
REQ-016 All outputs except in_ready and mul_flush SHALL be registered.

Reset
REQ-017 rst = 0 SHALL immediately force IDLE, mul_valid = 0, wb_valid = 0, wb_data = 0, wb_rd = 0, multiplicand = multiplier = 0, mulw = 0, mul_signed = 0; in_ready = 1 after release.
REQ-018 Reset mid-operation SHALL discard the op; no wb_valid after release until a new op completes.

Verification
REQ-019 MUL src1=3, src2=0xFFFFFFFFFFFFFFFE -> mul_signed=11, wb_data=0xFFFFFFFFFFFFFFFA, wb_rd equals in_rd.
REQ-020 MULHU src1=src2=0xFFFFFFFFFFFFFFFF -> mul_signed=00, wb_data=0xFFFFFFFFFFFFFFFE; MULHSU src1=0xFFFFFFFFFFFFFFFF, src2=2 -> wb_data=0xFFFFFFFFFFFFFFFF.
REQ-021 MULW src1=0xDEADBEEF7FFFFFFF, src2=0x1234567800000002 -> mulw=1, wb_data=0xFFFFFFFFFFFFFFFE.
REQ-022 MULH src1=0, src2=5 -> mul_valid stays 0, wb_valid one cycle after accept, wb_data=0; MULW src2=0x0000000100000000 -> also bypassed, wb_data=0.
REQ-023 Flush in WAIT, then multiplier raises out_valid -> mul_flush pulsed, in_ready=1 next cycle, no wb_valid ever for that op.
REQ-024 wb_ready held 0 for 10 cycles in DONE -> wb_valid, wb_data, wb_rd constant, in_ready=0; release -> one writeback, IDLE next cycle; rst=0 asserted in ISSUE -> mul_valid=0 immediately.
